// File: rtl/uart_multi_ssd_display_pkg.sv
// Shared segment constants, hex glyph table and received-byte payload for the UART SSD display.
package uart_ssd_pkg;

   localparam int unsigned SEG_W = 7;

   // Segment order {g,f,e,d,c,b,a}, active-low
   localparam logic [SEG_W-1:0] SEG_DASH  = 7'b0111111;
   localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

   localparam logic [15:0][SEG_W-1:0] HEX_GLYPH = {
      7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110,   // F E d C
      7'b0000011, 7'b0001000, 7'b0010000, 7'b0000000,   // b A 9 8
      7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,   // 7 6 5 4
      7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000    // 3 2 1 0
   };

   typedef struct packed {
      logic [3:0] hi;
      logic [3:0] lo;
   } rx_byte_t;

   function automatic logic [SEG_W-1:0] seg_decode(input logic [3:0] nib);
      return HEX_GLYPH[nib];
   endfunction

endpackage

// File: rtl/uart_multi_ssd_display_if.sv
// Byte stream from the UART receiver plus display clear into the SSD display.
interface uart_multi_ssd_display_if;
   import uart_ssd_pkg::*;

   rx_byte_t rx_data;
   logic     rx_valid;
   logic     clr;

   modport master (output rx_data, rx_valid, clr);
   modport slave  (input  rx_data, rx_valid, clr);

endinterface

// File: rtl/ssd_scan_ctrl.sv
// Digit multiplex scanner: prescaler, rotating digit index and one-cold digit select.
module ssd_scan_ctrl #(
   parameter int unsigned NUM_DIGITS = 4,
   parameter int unsigned SCAN_DIV   = 416_667
) (
   input  logic                          clk,
   input  logic                          rst,
   output logic                          tick_c,
   output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
   output logic [NUM_DIGITS-1:0]         dig_sel
);

   localparam int unsigned IDX_W = $clog2(NUM_DIGITS);
   localparam int unsigned PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

   logic [PRE_W-1:0] presc;

   assign tick_c = (presc == PRE_W'(SCAN_DIV - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)        presc <= '0;
      else if (tick_c) presc <= '0;
      else             presc <= presc + PRE_W'(1);
   end

   // Select the current digit on the tick, then move the index on for the next one
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         digit_idx <= '0;
         dig_sel   <= '1;
      end else if (tick_c) begin
         dig_sel   <= ~(NUM_DIGITS'(1) << digit_idx);
         digit_idx <= (digit_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : digit_idx + IDX_W'(1);
      end
   end

endmodule

// File: rtl/uart_multi_ssd_display.sv
// Shows received UART bytes as hex digits on a multiplexed seven-segment display.
// Optional idle blanking of the display is enabled by defining SSD_IDLE_BLANK_EN.
module uart_multi_ssd_display
   import uart_ssd_pkg::*;
#(
   parameter int unsigned NUM_DIGITS     = 4,
   parameter int unsigned SCAN_DIV       = 416_667,
   parameter int unsigned STARTUP_CYCLES = 50_000_000,
   parameter int unsigned IDLE_CYCLES    = 250_000_000
) (
   input  logic                     clk,
   input  logic                     rst,
   uart_multi_ssd_display_if.slave  rx_if,
   output logic [SEG_W-1:0]         segments,
   output logic [NUM_DIGITS-1:0]    dig_sel
);

   localparam int unsigned IDX_W   = $clog2(NUM_DIGITS);
   localparam int unsigned FILL_W  = $clog2(NUM_DIGITS + 1);
   localparam int unsigned START_W = $clog2(STARTUP_CYCLES + 1);

   logic [NUM_DIGITS-1:0][3:0] nib_buf;
   logic [NUM_DIGITS-1:0][3:0] buf_shift;
   logic [FILL_W-1:0]          fill;
   logic [FILL_W-1:0]          fill_inc;
   logic [START_W-1:0]         startup_cnt;
   logic                       startup_done;
   logic                       accept;
   logic                       scan_tick;
   logic [IDX_W-1:0]           digit_idx;
   logic [3:0]                 cur_nib;
   logic                       cur_filled;

   // Startup window: counts up once after reset and then holds
   assign startup_done = (startup_cnt == START_W'(STARTUP_CYCLES));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)              startup_cnt <= '0;
      else if (!startup_done) startup_cnt <= startup_cnt + START_W'(1);
   end

   assign accept = rx_if.rx_valid && startup_done && !rx_if.clr;

   always_comb begin
      buf_shift = '0;
      for (int i = 2; i < int'(NUM_DIGITS); i++) buf_shift[i] = nib_buf[i-2];
      buf_shift[1] = rx_if.rx_data.hi;
      buf_shift[0] = rx_if.rx_data.lo;
   end

   assign fill_inc = (fill >= FILL_W'(NUM_DIGITS - 2)) ? FILL_W'(NUM_DIGITS) : fill + FILL_W'(2);

`ifdef SSD_IDLE_BLANK_EN
   localparam int unsigned IDLE_W = $clog2(IDLE_CYCLES + 1);

   logic [IDLE_W-1:0] idle_cnt;
   logic              idle_expired;

   assign idle_expired = (idle_cnt == IDLE_W'(IDLE_CYCLES));

   // Holds at the limit so the blanking persists until the next byte
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                          idle_cnt <= '0;
      else if (rx_if.clr || accept)      idle_cnt <= '0;
      else if (!idle_expired)            idle_cnt <= idle_cnt + IDLE_W'(1);
   end
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         nib_buf <= '0;
         fill    <= '0;
      end else if (rx_if.clr) begin
         nib_buf <= '0;
         fill    <= '0;
      end else if (accept) begin
         nib_buf <= buf_shift;
         fill    <= fill_inc;
      end
`ifdef SSD_IDLE_BLANK_EN
      else if (idle_expired) begin
         fill <= '0;
      end
`endif
   end

   ssd_scan_ctrl #(
      .NUM_DIGITS (NUM_DIGITS),
      .SCAN_DIV   (SCAN_DIV)
   ) u_scan (
      .clk       (clk),
      .rst       (rst),
      .tick_c    (scan_tick),
      .digit_idx (digit_idx),
      .dig_sel   (dig_sel)
   );

   // Segments are latched alongside dig_sel for the digit being selected on this tick
   assign cur_nib    = nib_buf[digit_idx];
   assign cur_filled = (FILL_W'(digit_idx) < fill);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)           segments <= SEG_BLANK;
      else if (scan_tick) segments <= cur_filled ? seg_decode(cur_nib) : SEG_DASH;
   end

endmodule

// File: tb/tb_uart_multi_ssd_display.sv
// Directed bench for uart_multi_ssd_display with NUM_DIGITS=4, SCAN_DIV=4, STARTUP=10, IDLE=50.
module tb_uart_multi_ssd_display;
   import uart_ssd_pkg::*;

   localparam logic [6:0] D   = 7'b0111111;
   localparam logic [6:0] G_0 = 7'b1000000;
   localparam logic [6:0] G_1 = 7'b1111001;
   localparam logic [6:0] G_2 = 7'b0100100;
   localparam logic [6:0] G_3 = 7'b0110000;
   localparam logic [6:0] G_4 = 7'b0011001;
   localparam logic [6:0] G_5 = 7'b0010010;
   localparam logic [6:0] G_6 = 7'b0000010;
   localparam logic [6:0] G_9 = 7'b0010000;
   localparam logic [6:0] G_b = 7'b0000011;
   localparam logic [6:0] G_C = 7'b1000110;
   localparam logic [6:0] G_d = 7'b0100001;
   localparam logic [6:0] G_E = 7'b0000110;
   localparam logic [6:0] G_F = 7'b0001110;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [6:0] segments;
   logic [3:0] dig_sel;
   int         checks   = 0;
   int         failures = 0;
   logic [6:0] cap_seg [4];
   int         bad_sel;

   uart_multi_ssd_display_if rx_if ();

   uart_multi_ssd_display #(
      .NUM_DIGITS     (4),
      .SCAN_DIV       (4),
      .STARTUP_CYCLES (10),
      .IDLE_CYCLES    (50)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .rx_if    (rx_if),
      .segments (segments),
      .dig_sel  (dig_sel)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      rx_if.rx_data  = rx_byte_t'(b);
      rx_if.rx_valid = 1'b1;
      step();
      rx_if.rx_valid = 1'b0;
   endtask

   // Release lands 1 time unit after a rising edge; that edge counts as edge 0
   task automatic do_reset();
      rst            = 1'b0;
      rx_if.rx_valid = 1'b0;
      rx_if.clr      = 1'b0;
      rx_if.rx_data  = rx_byte_t'(8'h00);
      step();
      step();
      rst = 1'b1;
   endtask

   // Two full scan sweeps; keeps the last glyph seen for each selected digit
   task automatic capture();
      for (int j = 0; j < 4; j++) cap_seg[j] = 7'bx;
      bad_sel = 0;
      for (int c = 0; c < 32; c++) begin
         step();
         for (int j = 0; j < 4; j++)
            if (dig_sel === 4'(~(4'b0001 << j))) cap_seg[j] = segments;
         if ($countones(~dig_sel) != 1) bad_sel++;
      end
   endtask

   task automatic test_reset();
      logic [3:0] exp_sel [5];
      exp_sel = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};
      rst = 1'b0;
      rx_if.rx_valid = 1'b0;
      rx_if.clr      = 1'b0;
      rx_if.rx_data  = rx_byte_t'(8'h00);
      step();
      checks++;
      if (segments !== 7'b1111111) begin failures++; $display("FAIL reset_seg: got %b want 1111111", segments); end
      checks++;
      if (dig_sel !== 4'b1111) begin failures++; $display("FAIL reset_sel: got %b want 1111", dig_sel); end
      rst = 1'b1;
      repeat (3) step();
      checks++;
      if (dig_sel !== 4'b1111) begin failures++; $display("FAIL pre_tick_sel: got %b want 1111", dig_sel); end
      for (int k = 0; k < 5; k++) begin
         step();
         checks++;
         if (dig_sel !== exp_sel[k]) begin failures++; $display("FAIL scan_sel%0d: got %b want %b", k, dig_sel, exp_sel[k]); end
         checks++;
         if (segments !== D) begin failures++; $display("FAIL scan_dash%0d: got %b want %b", k, segments, D); end
         repeat (3) step();
      end
   endtask

   task automatic test_startup_ignore();
      logic [6:0] exp [4];
      do_reset();
      repeat (4) step();
      send_byte(8'hA5);                  // edge 5: inside startup window
      repeat (14) step();
      send_byte(8'h3C);                  // edge 20
      capture();
      exp = '{G_C, G_3, D, D};
      for (int j = 0; j < 4; j++) begin
         checks++;
         if (cap_seg[j] !== exp[j]) begin failures++; $display("FAIL startup digit%0d: got %b want %b", j, cap_seg[j], exp[j]); end
      end
      checks++;
      if (bad_sel !== 0) begin failures++; $display("FAIL startup onecold: got %0d bad samples want 0", bad_sel); end
   endtask

   task automatic test_startup_edge();
      logic [6:0] exp [4];
      do_reset();
      repeat (9) step();
      send_byte(8'h11);                  // edge 10: last ignored edge
      send_byte(8'h22);                  // edge 11: first accepted edge
      capture();
      exp = '{G_2, G_2, D, D};
      for (int j = 0; j < 4; j++) begin
         checks++;
         if (cap_seg[j] !== exp[j]) begin failures++; $display("FAIL startup_edge digit%0d: got %b want %b", j, cap_seg[j], exp[j]); end
      end
   endtask

   task automatic test_fill_saturate();
      logic [6:0] exp [4];
      do_reset();
      repeat (12) step();
      send_byte(8'h12);
      send_byte(8'h34);
      send_byte(8'h56);
      capture();
      exp = '{G_6, G_5, G_4, G_3};
      for (int j = 0; j < 4; j++) begin
         checks++;
         if (cap_seg[j] !== exp[j]) begin failures++; $display("FAIL fill digit%0d: got %b want %b", j, cap_seg[j], exp[j]); end
      end
      checks++;
      if (bad_sel !== 0) begin failures++; $display("FAIL fill onecold: got %0d bad samples want 0", bad_sel); end
   endtask

   task automatic test_clr();
      logic [6:0] exp [4];
      rx_if.clr      = 1'b1;
      rx_if.rx_valid = 1'b1;
      rx_if.rx_data  = rx_byte_t'(8'h77);
      step();
      rx_if.clr      = 1'b0;
      rx_if.rx_valid = 1'b0;
      capture();
      exp = '{D, D, D, D};
      for (int j = 0; j < 4; j++) begin
         checks++;
         if (cap_seg[j] !== exp[j]) begin failures++; $display("FAIL clr digit%0d: got %b want %b", j, cap_seg[j], exp[j]); end
      end
      send_byte(8'h9B);
      capture();
      exp = '{G_b, G_9, D, D};
      for (int j = 0; j < 4; j++) begin
         checks++;
         if (cap_seg[j] !== exp[j]) begin failures++; $display("FAIL after_clr digit%0d: got %b want %b", j, cap_seg[j], exp[j]); end
      end
   endtask

   task automatic test_glyphs();
      logic [6:0] exp [4];
      send_byte(8'hED);
      capture();
      exp = '{G_d, G_E, G_b, G_9};
      for (int j = 0; j < 4; j++) begin
         checks++;
         if (cap_seg[j] !== exp[j]) begin failures++; $display("FAIL glyph_ed digit%0d: got %b want %b", j, cap_seg[j], exp[j]); end
      end
      send_byte(8'hF0);
      capture();
      exp = '{G_0, G_F, G_d, G_E};
      for (int j = 0; j < 4; j++) begin
         checks++;
         if (cap_seg[j] !== exp[j]) begin failures++; $display("FAIL glyph_f0 digit%0d: got %b want %b", j, cap_seg[j], exp[j]); end
      end
   endtask

   task automatic test_idle();
      logic [6:0] exp [4];
      do_reset();
      repeat (12) step();
      send_byte(8'h0F);
      repeat (60) step();
      capture();
`ifdef SSD_IDLE_BLANK_EN
      exp = '{D, D, D, D};
`else
      exp = '{G_F, G_0, D, D};
`endif
      for (int j = 0; j < 4; j++) begin
         checks++;
         if (cap_seg[j] !== exp[j]) begin failures++; $display("FAIL idle digit%0d: got %b want %b", j, cap_seg[j], exp[j]); end
      end
      send_byte(8'h21);
      capture();
`ifdef SSD_IDLE_BLANK_EN
      exp = '{G_1, G_2, D, D};
`else
      exp = '{G_1, G_2, G_F, G_0};
`endif
      for (int j = 0; j < 4; j++) begin
         checks++;
         if (cap_seg[j] !== exp[j]) begin failures++; $display("FAIL idle_next digit%0d: got %b want %b", j, cap_seg[j], exp[j]); end
      end
   endtask

   task automatic test_reset_mid();
      logic [6:0] exp [4];
      do_reset();
      repeat (12) step();
      send_byte(8'h12);
      send_byte(8'h34);
      repeat (6) step();
      #2 rst = 1'b0;                     // asserted between clock edges
      #1;
      checks++;
      if (segments !== 7'b1111111) begin failures++; $display("FAIL mid_reset_seg: got %b want 1111111", segments); end
      checks++;
      if (dig_sel !== 4'b1111) begin failures++; $display("FAIL mid_reset_sel: got %b want 1111", dig_sel); end
      step();
      step();
      rst = 1'b1;
      rx_if.rx_data  = rx_byte_t'(8'h55);
      rx_if.rx_valid = 1'b1;
      repeat (10) step();                // edges 1..10 all inside the restarted window
      rx_if.rx_valid = 1'b0;
      capture();
      exp = '{D, D, D, D};
      for (int j = 0; j < 4; j++) begin
         checks++;
         if (cap_seg[j] !== exp[j]) begin failures++; $display("FAIL restart_window digit%0d: got %b want %b", j, cap_seg[j], exp[j]); end
      end
      send_byte(8'h66);
      capture();
      exp = '{G_6, G_6, D, D};
      for (int j = 0; j < 4; j++) begin
         checks++;
         if (cap_seg[j] !== exp[j]) begin failures++; $display("FAIL post_restart digit%0d: got %b want %b", j, cap_seg[j], exp[j]); end
      end
   endtask

   initial begin
      rx_if.rx_valid = 1'b0;
      rx_if.clr      = 1'b0;
      rx_if.rx_data  = rx_byte_t'(8'h00);
      test_reset();
      test_startup_ignore();
      test_startup_edge();
      test_fill_saturate();
      test_clr();
      test_glyphs();
      test_idle();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/uart_multi_ssd_display.md
UART_MULTI_SSD_DISPLAY -- requirements
Module: uart_multi_ssd_display

Interface
REQ-001 Parameter NUM_DIGITS, 4, digit count; SHALL be even and >= 2.
REQ-002 Parameter SCAN_DIV, 416_667, clk cycles each digit stays selected.
REQ-003 Parameter STARTUP_CYCLES, 50_000_000, post-reset window during which bytes are ignored.
REQ-004 Parameter IDLE_CYCLES, 250_000_000, no-byte timeout; used only with SSD_IDLE_BLANK_EN.
REQ-005 clk  input  1  system clock; single clock domain.
REQ-006 rst  input  1  reset, asynchronous, active-low.
REQ-007 rx_data  input  8  byte from UART receiver.
REQ-008 rx_valid  input  1  one-cycle strobe qualifying rx_data.
REQ-009 clr  input  1  synchronous clear of the display buffer.
REQ-010 segments  output  7  {g,f,e,d,c,b,a}, active-low, registered.
REQ-011 dig_sel  output  NUM_DIGITS  one-cold digit enable, active-low, registered.

Function
REQ-012 Buffer SHALL hold NUM_DIGITS nibbles; an accepted byte shifts the buffer up two digits, rx_data[3:0] into digit 0, rx_data[7:4] into digit 1, top two nibbles discarded.
REQ-013 Fill count SHALL increment by 2 per accepted byte, saturating at NUM_DIGITS.
REQ-014 Digit i SHALL show a dash (7'b0111111) when i >= fill count, else the hex glyph of its nibble (0 = 7'b1000000, F = 7'b0001110).
REQ-015 Byte SHALL be accepted when rx_valid=1, startup window expired, and clr=0.
REQ-016 clr=1 SHALL zero buffer and fill count next cycle; simultaneous rx_valid byte is dropped.
REQ-017 rx_valid during the startup window SHALL be ignored with no state change.
REQ-018 Scan prescaler SHALL count 0..SCAN_DIV-1; at terminal count digit index advances i -> (i+1) mod NUM_DIGITS, wrapping NUM_DIGITS-1 -> 0.
REQ-019 At each terminal count dig_sel and segments SHALL update on the same edge, from buffer state before that edge; latency byte-to-visible <= NUM_DIGITS*SCAN_DIV cycles.
REQ-020 Exactly one dig_sel bit SHALL be low after the first terminal count; none before it.

Reset
REQ-021 On rst low: segments=7'b1111111, dig_sel all ones, buffer=0, fill=0, digit index=0, prescaler=0, startup and idle counters=0.
REQ-022 Reset asserted mid-scan or mid-startup SHALL restart the startup window in full on release.

Configuration
REQ-023 Macro SSD_IDLE_BLANK_EN defined: counter clears on each accepted byte or clr; reaching IDLE_CYCLES SHALL set fill=0 (all dashes), buffer retained, counter holds until next byte.
REQ-024 SSD_IDLE_BLANK_EN undefined: no idle counter logic; display holds last content indefinitely.

Structure
REQ-025 Package uart_ssd_pkg SHALL hold segment constants (SEG_DASH, SEG_BLANK, 16-entry hex glyph table) and the nibble-to-segment decode function.
REQ-026 Sub-module ssd_scan_ctrl SHALL own prescaler, digit index and dig_sel generation; top owns buffer, fill, startup and idle logic.

Verification (NUM_DIGITS=4, SCAN_DIV=4, STARTUP_CYCLES=10, IDLE_CYCLES=50)
REQ-027 Reset, no bytes, scan 4 digits -> every digit shows 7'b0111111; dig_sel cycles 1110,1101,1011,0111,1110.
REQ-028 rx 0xA5 at cycle 5 then 0x3C at cycle 20 -> first ignored; digit0=C, digit1=3, digits 2-3 dash.
REQ-029 bytes 0x12,0x34,0x56 after startup -> digits 3..0 show 3,4,5,6; fill stays 4.
REQ-030 clr and rx_valid (0x77) same cycle -> byte dropped, all four digits dash.
REQ-031 With SSD_IDLE_BLANK_EN, byte 0x0F then 50 idle cycles -> all dashes; next byte 0x21 -> digit0=1, digit1=2, digits 2-3 dash.
REQ-032 rst low mid-scan with buffer full -> outputs 7'b1111111/1111 same cycle asynchronously; bytes ignored for 10 cycles after release.
